gmii_frame_gen: RTL and testbench

- Synthesizable, parametrised GMII transmit stimulus source; next generation of the fixed-sequence PCS transmit tester.
- Drives TXD/TX_EN/TX_ER into the PCS Transmit block as full Ethernet-style frames: preamble, SFD, programmable-length payload, inter-packet gap.
- Sends a programmable burst of back-to-back frames and aborts on COL.
- Used in PCS transmit benches and in loopback builds in place of hand-coded stimulus.

---
 rtl/gmii_frame_gen.sv | 193 +++++++++++++++++++
 tb/tb_gmii_frame_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_gen.sv
// GMII transmit frame generator: bursts of preamble/SFD/payload/IPG frames, aborted on COL.
// Optional TX_ER injection on one payload byte is compiled in with GMII_FRAME_GEN_ERR_INJECT_EN.
`timescale 1ns/1ps
module gmii_frame_gen #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IPG_LEN      = 12,
    parameter int unsigned LEN_W        = 11,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DATA_MODE    = 0
) (
    input  logic             GTX_CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [CNT_W-1:0] frame_cnt,
    input  logic [7:0]       seed,
`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
    input  logic [LEN_W-1:0] err_idx,
    input  logic             err_en,
`endif
    input  logic             COL,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] col_count
);

    localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int unsigned IPG_W = $clog2(IPG_LEN + 1);
    localparam int unsigned CW0   = (PRE_W > IPG_W) ? PRE_W : IPG_W;
    localparam int unsigned CW    = (CW0 > LEN_W) ? CW0 : LEN_W;
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] IPG_LAST = CW'(IPG_LEN - 1);

    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StIpg} state_t;

    state_t           r_state, w_state_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_remain, w_remain_d;
    logic [7:0]       r_byte, w_byte_d;
    logic [LEN_W-1:0] r_len_last;
    logic [7:0]       r_first;
    logic [7:0]       r_txd, w_txd_d;
    logic             r_tx_en, r_busy, r_done, w_done_d;
    logic [CNT_W-1:0] r_col_count;
    logic             w_accept, w_col_hit;
    logic [7:0]       w_first;
    logic [LEN_W-1:0] w_len_last;

    // Galois form: multiply by x modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h71 : 8'h00);
    endfunction

    assign w_first    = (DATA_MODE == 1 && seed == 8'h00) ? 8'hFF : seed;
    assign w_len_last = (payload_len == '0) ? '0 : payload_len - LEN_W'(1);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt + CW'(1);
        w_remain_d = r_remain;
        w_byte_d   = r_byte;
        w_accept   = 1'b0;
        w_col_hit  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (start && frame_cnt != '0) begin
                    w_accept   = 1'b1;
                    w_state_d  = StPre;
                    w_remain_d = frame_cnt;
                end
            end
            StPre: begin
                if (COL) begin
                    w_state_d  = StIpg;
                    w_cnt_d    = '0;
                    w_remain_d = r_remain - CNT_W'(1);
                    w_col_hit  = 1'b1;
                end else if (r_cnt == PRE_LAST) begin
                    w_state_d = StSfd;
                    w_cnt_d   = '0;
                end
            end
            StSfd: begin
                w_cnt_d    = '0;
                w_remain_d = r_remain - CNT_W'(1);
                if (COL) begin
                    w_state_d = StIpg;
                    w_col_hit = 1'b1;
                end else begin
                    w_state_d = StData;
                    w_byte_d  = r_first;
                end
            end
            StData: begin
                if (COL) begin
                    w_state_d = StIpg;
                    w_cnt_d   = '0;
                    w_col_hit = 1'b1;
                end else if (r_cnt == CW'(r_len_last)) begin
                    w_state_d = StIpg;
                    w_cnt_d   = '0;
                end else begin
                    w_byte_d = (DATA_MODE == 1) ? lfsr_next(r_byte) : r_byte + 8'd1;
                end
            end
            StIpg: begin
                if (r_cnt == IPG_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = (r_remain != '0) ? StPre : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // done coincides with the final IPG cycle of the burst.
    always_comb begin
        w_done_d = (w_state_d == StIpg) && (w_remain_d == '0) && (w_cnt_d == IPG_LAST);
        unique case (w_state_d)
            StPre:   w_txd_d = 8'h55;
            StSfd:   w_txd_d = 8'hD5;
            StData:  w_txd_d = w_byte_d;
            default: w_txd_d = 8'h00;
        endcase
    end

    always_ff @(posedge GTX_CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_remain    <= '0;
            r_byte      <= 8'h00;
            r_len_last  <= '0;
            r_first     <= 8'h00;
            r_txd       <= 8'h00;
            r_tx_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_col_count <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_remain <= w_remain_d;
            r_byte   <= w_byte_d;
            if (w_accept) begin
                r_len_last <= w_len_last;
                r_first    <= w_first;
            end
            r_txd   <= w_txd_d;
            r_tx_en <= (w_state_d == StPre) || (w_state_d == StSfd) || (w_state_d == StData);
            r_busy  <= (w_state_d != StIdle);
            r_done  <= w_done_d;
            if (w_col_hit && r_col_count != '1) begin
                r_col_count <= r_col_count + CNT_W'(1);
            end
        end
    end

`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
    logic             r_err_en;
    logic [LEN_W-1:0] r_err_idx;
    logic             r_tx_er;

    always_ff @(posedge GTX_CLK or posedge RESET) begin
        if (RESET) begin
            r_err_en  <= 1'b0;
            r_err_idx <= '0;
            r_tx_er   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err_en  <= err_en;
                r_err_idx <= err_idx;
            end
            r_tx_er <= r_err_en && (w_state_d == StData) && (w_cnt_d == CW'(r_err_idx));
        end
    end

    assign TX_ER = r_tx_er;
`else
    assign TX_ER = 1'b0;
`endif

    assign TXD       = r_txd;
    assign TX_EN     = r_tx_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign col_count = r_col_count;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Bench for gmii_frame_gen: incrementing-data and LFSR-data instances share stimulus and are
// compared cycle by cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_gmii_frame_gen;

    localparam int P  = 7;
    localparam int IL = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        col;
    logic [10:0] plen;
    logic [7:0]  fcnt;
    logic [7:0]  seed;
    logic [10:0] err_idx;
    logic        err_en;

    logic [7:0]  txd     [2];
    logic        en      [2];
    logic        er      [2];
    logic        busy    [2];
    logic        done    [2];
    logic [7:0]  col_cnt [2];

    int checks = 0;
    int errors = 0;
    int exp_col = 0;

    always #5 clk = ~clk;

    gmii_frame_gen #(.PREAMBLE_LEN(P), .IPG_LEN(IL), .LEN_W(11), .CNT_W(8), .DATA_MODE(0)) u_dut0 (
        .GTX_CLK(clk), .RESET(rst), .start(start), .payload_len(plen), .frame_cnt(fcnt),
        .seed(seed),
`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
        .err_idx(err_idx), .err_en(err_en),
`endif
        .COL(col), .TXD(txd[0]), .TX_EN(en[0]), .TX_ER(er[0]), .busy(busy[0]), .done(done[0]),
        .col_count(col_cnt[0])
    );

    gmii_frame_gen #(.PREAMBLE_LEN(P), .IPG_LEN(IL), .LEN_W(11), .CNT_W(8), .DATA_MODE(1)) u_dut1 (
        .GTX_CLK(clk), .RESET(rst), .start(start), .payload_len(plen), .frame_cnt(fcnt),
        .seed(seed),
`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
        .err_idx(err_idx), .err_en(err_en),
`endif
        .COL(col), .TXD(txd[1]), .TX_EN(en[1]), .TX_ER(er[1]), .busy(busy[1]), .done(done[1]),
        .col_count(col_cnt[1])
    );

    // Reference payload: GF(2^8) multiplication by x modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] gf_mulx(input logic [7:0] b);
        logic [8:0] t;
        t = {b, 1'b0};
        if (t[8]) t = t ^ 9'h171;
        return t[7:0];
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input logic [7:0] s, input int i);
        logic [7:0] b;
        if (mode == 0) begin
            b = s + 8'(i);
        end else begin
            b = (s == 8'h00) ? 8'hFF : s;
            for (int j = 0; j < i; j++) b = gf_mulx(b);
        end
        return b;
    endfunction

    // Expected word per cycle: {busy, done, tx_en, tx_er, txd}.
    task automatic run_burst(input string name, input int len, input int cnt, input logic [7:0] s,
                             input int col_frame, input int col_off, input int busy_cyc,
                             input bit inj_en, input int inj_idx);
        logic [11:0] q0[$];
        logic [11:0] q1[$];
        bit          qc[$];
        int          lc, act, dn, pi;
        bit          hit, e;
        logic [7:0]  d0, d1;
        logic [11:0] obs;
        lc = (len == 0) ? 1 : len;
        dn = -1;
        for (int f = 0; f < cnt; f++) begin
            act = P + 1 + lc;
            hit = (f == col_frame) && (col_off < act);
            if (hit) begin
                act = col_off + 1;
                exp_col++;
            end
            for (int k = 0; k < act; k++) begin
                pi = k - P - 1;
                d0 = (k < P) ? 8'h55 : (k == P) ? 8'hD5 : exp_byte(0, s, pi);
                d1 = (k < P) ? 8'h55 : (k == P) ? 8'hD5 : exp_byte(1, s, pi);
                e  = inj_en && (k > P) && (pi == inj_idx);
                q0.push_back({1'b1, 1'b0, 1'b1, e, d0});
                q1.push_back({1'b1, 1'b0, 1'b1, e, d1});
                qc.push_back(hit && (k == col_off));
            end
            for (int k = 0; k < IL; k++) begin
                e = (f == cnt - 1) && (k == IL - 1);
                if (e) dn = q0.size();
                q0.push_back({1'b1, e, 1'b0, 1'b0, 8'h00});
                q1.push_back({1'b1, e, 1'b0, 1'b0, 8'h00});
                qc.push_back($urandom_range(0, 3) == 0);
            end
        end
        q0.push_back(12'h000);
        q1.push_back(12'h000);
        qc.push_back($urandom_range(0, 1) == 1);

        @(negedge clk);
        plen    = 11'(len);
        fcnt    = 8'(cnt);
        seed    = s;
        err_en  = inj_en;
        err_idx = 11'(inj_idx);
        start   = 1'b1;
        col     = 1'b0;
        for (int i = 0; i < q0.size(); i++) begin
            @(negedge clk);
            obs = {busy[0], done[0], en[0], er[0], txd[0]};
            checks++;
            if (obs !== q0[i]) begin
                errors++;
                $display("FAIL %s mode0 cycle %0d: got %h expected %h", name, i, obs, q0[i]);
            end
            obs = {busy[1], done[1], en[1], er[1], txd[1]};
            checks++;
            if (obs !== q1[i]) begin
                errors++;
                $display("FAIL %s mode1 cycle %0d: got %h expected %h", name, i, obs, q1[i]);
            end
            start = 1'b0;
            col   = qc[i];
            if (i == busy_cyc || i == dn) begin
                start   = 1'b1;
                plen    = 11'($urandom_range(0, 40));
                fcnt    = 8'($urandom_range(1, 5));
                seed    = 8'($urandom);
                err_en  = 1'($urandom);
                err_idx = 11'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        start = 1'b0;
        col   = 1'b0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (col_cnt[m] !== 8'(exp_col)) begin
                errors++;
                $display("FAIL %s col_count[%0d]: got %0d expected %0d", name, m, col_cnt[m], exp_col);
            end
        end
    endtask

    task automatic check_idle(input string name, input int n);
        logic [11:0] obs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                obs = {busy[m], done[m], en[m], er[m], txd[m]};
                checks++;
                if (obs !== 12'h000) begin
                    errors++;
                    $display("FAIL %s dut%0d cycle %0d: got %h expected 000", name, m, i, obs);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; col = 1'b0; plen = '0; fcnt = '0; seed = '0;
        err_en = 1'b0; err_idx = '0;
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({busy[m], done[m], en[m], er[m], txd[m], col_cnt[m]} !== 20'h0) begin
                errors++;
                $display("FAIL reset dut%0d: got %h expected 00000", m,
                         {busy[m], done[m], en[m], er[m], txd[m], col_cnt[m]});
            end
        end
        rst = 1'b0;
        exp_col = 0;
        check_idle("reset_idle", 2);
    endtask

    task automatic test_single_frame();
        run_burst("single", 6, 1, 8'h03, -1, 0, -1, 1'b0, 0);
    endtask

    task automatic test_lfsr_seed0();
        run_burst("lfsr_seed0", 3, 1, 8'h00, -1, 0, -1, 1'b0, 0);
        run_burst("len_zero", 0, 1, 8'h5A, -1, 0, -1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_burst("back_to_back", 2, 3, 8'hFE, -1, 0, 12, 1'b0, 0);
    endtask

    task automatic test_collision();
        run_burst("col_data", 10, 2, 8'h10, 0, P + 3 - 1, -1, 1'b0, 0);
        run_burst("col_pre", 4, 3, 8'h20, 1, 3, -1, 1'b0, 0);
        run_burst("col_sfd", 4, 1, 8'h30, 0, P, -1, 1'b0, 0);
    endtask

    task automatic test_zero_count();
        @(negedge clk);
        fcnt = 8'h00; plen = 11'd5; start = 1'b1;
        check_idle("zero_count", 1);
        start = 1'b0;
        check_idle("zero_count", 3);
    endtask

    task automatic test_random();
        int len, cnt;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 20);
            cnt = $urandom_range(1, 3);
            run_burst("random", len, cnt, 8'($urandom), $urandom_range(0, 3) - 1,
                      $urandom_range(0, P + len + 3), $urandom_range(0, 30), 1'b0, 0);
        end
    endtask

`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
    task automatic test_err_inject();
        run_burst("err_idx2", 4, 2, 8'h40, -1, 0, -1, 1'b1, 2);
        run_burst("err_idx4", 4, 1, 8'h41, -1, 0, -1, 1'b1, 4);
    endtask
`endif

    task automatic test_reset_mid_frame();
        @(negedge clk);
        plen = 11'd10; fcnt = 8'd2; seed = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (P + 3) @(negedge clk);
        checks++;
        if (en[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre-check tx_en: got %b expected 1", en[0]);
        end
        #2 rst = 1'b1;
        start = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({busy[m], en[m], txd[m], col_cnt[m]} !== 18'h0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: got %h expected 00000", m,
                         {busy[m], en[m], txd[m], col_cnt[m]});
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        exp_col = 0;
        check_idle("after_reset", 2);
        run_burst("recover", 5, 1, 8'h99, -1, 0, 4, 1'b0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_lfsr_seed0();
        test_back_to_back();
        test_collision();
        test_zero_count();
        test_random();
`ifdef GMII_FRAME_GEN_ERR_INJECT_EN
        test_err_inject();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
